// File: rtl/fifo_stream_checker.sv
// Read-side FIFO consumer: drains num_words words and checks them against an incrementing pattern.
// Optional random read stalls when FIFO_CHK_STALL_EN is defined.
module fifo_stream_checker #(
    parameter int unsigned               DATA_WIDTH   = 8,
    parameter int unsigned               COUNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0]     EXPECT_START = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_words,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_dout,
    output logic                   fifo_rd_en,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [COUNT_WIDTH-1:0] err_count,
    output logic                   first_err_valid,
    output logic [COUNT_WIDTH-1:0] first_err_idx,
    output logic [DATA_WIDTH-1:0]  first_err_data
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                 state, state_next;
    logic [COUNT_WIDTH-1:0] num_words_q;
    logic [COUNT_WIDTH-1:0] issued;
    logic [COUNT_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0]  expected;
    logic                   cmp_valid;
    logic                   start_accept;
    logic                   stall;

    assign start_accept = start && (state == IDLE || state == DONE);

`ifdef FIFO_CHK_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, reseeded on every accepted start.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            lfsr <= 16'hACE1;
        end else if (state == RUN) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (num_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                fifo_rd_en = !fifo_empty && (issued != num_words_q) && !stall;
                if (fifo_rd_en && (issued == num_words_q - COUNT_WIDTH'(1))) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FLUSH);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            num_words_q     <= '0;
            issued          <= '0;
            idx             <= '0;
            expected        <= '0;
            cmp_valid       <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_data  <= '0;
        end else begin
            cmp_valid <= fifo_rd_en;
            if (start_accept) begin
                num_words_q     <= num_words;
                issued          <= '0;
                idx             <= '0;
                expected        <= EXPECT_START;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                first_err_data  <= '0;
            end else begin
                if (fifo_rd_en) begin
                    issued <= issued + COUNT_WIDTH'(1);
                end
                // Compare stage trails each strobe by one cycle, matching FIFO read latency.
                if (cmp_valid) begin
                    if (fifo_dout != expected) begin
                        if (err_count != '1) begin
                            err_count <= err_count + COUNT_WIDTH'(1);
                        end
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= idx;
                            first_err_data  <= fifo_dout;
                        end
                    end
                    expected <= expected + DATA_WIDTH'(1);
                    idx      <= idx + COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: doc/fifo_stream_checker.md
# fifo_stream_checker

Synthesizable read-side consumer for the team's synchronous FIFO: drains a programmed number of words through the FIFO read port and checks them against an incrementing counting pattern. It is the counterpart of the pattern writer on the FIFO's write side. It sits directly on the FIFO `dout`/`read_en`/`empty` port, so FIFO integrity can be checked in silicon and in simulation without a behavioural reader. It reports pass/fail, an error count and details of the first mismatch.

## Interface
- `DATA_WIDTH`, 8: FIFO word width and counting-pattern width.
- `COUNT_WIDTH`, 16: width of the word-count, index and error-count fields.
- `EXPECT_START`, 0: first expected data value.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a check run (sampled in IDLE or DONE only).
- `num_words` in COUNT_WIDTH: number of words to read; sampled with `start`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en` out 1: FIFO read strobe.
- `busy` out 1: high in RUN and FLUSH.
- `done` out 1: high in DONE.
- `pass` out 1: high in DONE when `err_count == 0`.
- `err_count` out COUNT_WIDTH: mismatches this run; saturates at all-ones.
- `first_err_valid` out 1: a mismatch has been captured this run.
- `first_err_idx` out COUNT_WIDTH: word index (0-based) of the first mismatch.
- `first_err_data` out DATA_WIDTH: `fifo_dout` value at the first mismatch.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: on `start`, latch `num_words`, clear the issue and compare counters, set the expected value to `EXPECT_START`, clear the error outputs, and go to RUN. If the latched `num_words == 0`, go to DONE instead.
- RUN: `fifo_rd_en = !fifo_empty && issued != num_words_q && !stall`. This output is combinational from registered state and `fifo_empty`. `issued` increments on each strobe. When the last read is issued, go to FLUSH.
- FLUSH: one cycle to compare the final word, then go to DONE.
- DONE: hold all results. `start` restarts the run exactly as from IDLE.
- `start` is ignored in RUN and FLUSH.
- Compare pipeline: `cmp_valid` is `fifo_rd_en` delayed by 1 cycle. On `cmp_valid`:
  - if `fifo_dout != expected`, increment `err_count` (saturating);
  - on the first mismatch, capture `idx`/`data` and set `first_err_valid`;
  - in all cases, increment `expected` and `idx`.
- `expected` wraps modulo 2^DATA_WIDTH. `issued` and `idx` never exceed `num_words_q`.
- `fifo_rd_en` is never asserted while `fifo_empty` is high and is never asserted outside RUN.
- Reset values: state IDLE; `fifo_rd_en`, `busy`, `done`, `pass`, `first_err_valid` all 0; every counter and capture register 0.
- Reset mid-run: the block returns to IDLE on the next edge and the partial results are discarded.

## Timing
- `start` sampled high at edge N puts the block in RUN from N+1. `fifo_rd_en` can first assert in cycle N+1.
- Without stalls, a non-empty FIFO gives one read per cycle.
- With the final strobe in cycle M, the final compare occurs in cycle M+1 (FLUSH) and `done` goes high in M+2.
- `num_words == 0`: `done`/`pass` go high the cycle after `start`.
- `fifo_empty` may toggle at any time. The read strobe simply gaps, and the compare still follows each strobe by exactly 1 cycle.

## Configuration
- `FIFO_CHK_STALL_EN` defined:
  - a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 at reset and at each `start`) advances every cycle in RUN;
  - `stall` = LFSR bit 0, which suppresses `fifo_rd_en` on roughly half the cycles to stress FIFO full/empty behaviour.
- Not defined: `stall` is tied to 0 and no LFSR logic is present.
- Data checking is identical in both builds.

## Test plan
- Writer pushes 0..99 into a depth-4 FIFO, `start` with `num_words = 100` -> 100 reads, `done = 1`, `pass = 1`, `err_count = 0`, `first_err_valid = 0`.
- Same stream, but word 37 is replaced with 0xFF -> `err_count = 1`, `first_err_idx = 37`, `first_err_data = 0xFF`, `pass = 0`.
- `num_words = 300` with DATA_WIDTH 8, writer counting modulo 256 -> `pass = 1` (expected value wraps 255 -> 0).
- `num_words = 0` -> `done` the cycle after `start`, `pass = 1`, `fifo_rd_en` never asserted.
- Writer stalls so `fifo_empty` toggles every 3 cycles, 20 words -> `fifo_rd_en` is never high while empty, `pass = 1`. Repeat with `FIFO_CHK_STALL_EN` defined for the same result.
- `reset` at word 10 of 50, then a fresh `start` with 50 and a fresh stream -> all outputs read 0 after reset, and the new run passes.
